// File: rtl/tk_pkg.sv
// Shared types and constants for the time keeper: BCD field types,
// power-on date/time, weekday encoding and month lengths.
package tk_pkg;

    typedef logic [3:0]  bcd_digit_t;
    typedef logic [7:0]  bcd_pair_t;
    typedef logic [15:0] bcd_year_t;
    typedef logic [3:0]  weekday_t;

    // Weekday encoding, Monday first
    localparam weekday_t WEEK_MON = 4'd1;
    localparam weekday_t WEEK_SAT = 4'd6;
    localparam weekday_t WEEK_SUN = 4'd7;

    // Date/time forced while reset is asserted
    localparam bcd_year_t RESET_YEAR   = 16'h2000;
    localparam bcd_pair_t RESET_MONTH  = 8'h01;
    localparam bcd_pair_t RESET_DAY    = 8'h01;
    localparam bcd_pair_t RESET_HOUR   = 8'h00;
    localparam bcd_pair_t RESET_MINUTE = 8'h00;
    localparam bcd_pair_t RESET_SEC    = 8'h00;
    localparam weekday_t  RESET_WEEK   = WEEK_SAT;

    // Field limits in BCD
    localparam bcd_pair_t MAX_SEC    = 8'h59;
    localparam bcd_pair_t MAX_MINUTE = 8'h59;
    localparam bcd_pair_t MAX_HOUR   = 8'h23;
    localparam bcd_pair_t MAX_MONTH  = 8'h12;

    // Month lengths in BCD
    localparam bcd_pair_t LEN_LONG     = 8'h31;
    localparam bcd_pair_t LEN_SHORT    = 8'h30;
    localparam bcd_pair_t LEN_FEB      = 8'h28;
    localparam bcd_pair_t LEN_FEB_LEAP = 8'h29;

    // Number of days in a (valid BCD) month
    function automatic bcd_pair_t month_length(input bcd_pair_t month, input logic leap);
        case (month)
            8'h04, 8'h06, 8'h09, 8'h11: month_length = LEN_SHORT;
            8'h02:                      month_length = leap ? LEN_FEB_LEAP : LEN_FEB;
            default:                    month_length = LEN_LONG;
        endcase
    endfunction

    // True when both digits of a pair are decimal
    function automatic logic bcd_pair_valid(input bcd_pair_t value);
        bcd_pair_valid = (value[7:4] <= 4'd9) && (value[3:0] <= 4'd9);
    endfunction

    // Digit-wise BCD increment of a pair; units 9 rolls into tens
    function automatic bcd_pair_t bcd_pair_inc(input bcd_pair_t value);
        if (value[3:0] == 4'd9) begin
            bcd_pair_inc = {value[7:4] + 4'd1, 4'd0};
        end else begin
            bcd_pair_inc = {value[7:4], value[3:0] + 4'd1};
        end
    endfunction

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD counter with synchronous clear, parallel load, increment
// enable and a run-time maximum; wraps to MIN_VALUE and flags a carry.
module bcd2_counter
    import tk_pkg::*;
#(
    parameter bcd_pair_t RESET_VALUE = 8'h00,
    parameter bcd_pair_t MIN_VALUE   = 8'h00
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      clear,
    input  logic      load,
    input  bcd_pair_t load_value,
    input  logic      inc,
    input  bcd_pair_t max_value,
    output bcd_pair_t value,
    output logic      carry
);

    logic at_max;

    // Treat anything at or beyond the limit as the wrap point so a stray
    // value can never count upward forever
    assign at_max = (value >= max_value);
    assign carry  = inc & at_max & ~clear & ~load;

    // Counter register: clear beats load, load beats increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= RESET_VALUE;
        end else if (clear) begin
            value <= MIN_VALUE;
        end else if (load) begin
            value <= load_value;
        end else if (inc) begin
            value <= at_max ? MIN_VALUE : bcd_pair_inc(value);
        end
    end

endmodule

// File: rtl/time_keeper.sv
// Calendar clock in BCD: prescaler, sec/min/hour/day/month counters,
// local year counter and weekday. Define TIME_KEEPER_LEAP_EN to give
// February 29 days in Gregorian leap years; otherwise it is always 28.
module time_keeper
    import tk_pkg::*;
#(
    parameter int CLK_HZ = 100000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] set_year,
    input  logic [7:0]  set_month,
    input  logic [7:0]  set_day,
    input  logic [7:0]  set_hour,
    input  logic [7:0]  set_minute,
    input  logic [7:0]  set_sec,
    input  logic [3:0]  set_week,
    output logic [15:0] year,
    output logic [7:0]  month,
    output logic [7:0]  day,
    output logic [7:0]  hour,
    output logic [7:0]  minute,
    output logic [7:0]  sec,
    output logic [3:0]  week,
    output logic        sec_pulse
);

    localparam int PRESC_W = $clog2(CLK_HZ);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_HZ - 1);

    logic [PRESC_W-1:0] prescaler;
    logic               wrap;
    logic               tick;
    logic               sec_carry, minute_carry, hour_carry, day_carry, month_carry;
    logic               run_leap, set_leap;
    bcd_pair_t          day_max, set_len;
    bcd_year_t          san_year;
    bcd_pair_t          san_month, san_day, san_hour, san_minute, san_sec;
    weekday_t           san_week;

    // Pair divisible by 4: even tens need units 0/4/8, odd tens need 2/6
    function automatic logic pair_div4(input bcd_pair_t pair);
        if (pair[4]) begin
            pair_div4 = (pair[3:0] == 4'd2) || (pair[3:0] == 4'd6);
        end else begin
            pair_div4 = (pair[3:0] == 4'd0) || (pair[3:0] == 4'd4) || (pair[3:0] == 4'd8);
        end
    endfunction

    // Gregorian rule on BCD digits; a century year defers to its upper pair
    function automatic logic is_leap(input bcd_year_t y);
        is_leap = (y[7:0] != 8'h00) ? pair_div4(y[7:0]) : pair_div4(y[15:8]);
    endfunction

    // Four-digit BCD increment; 9999 rolls to 0000
    function automatic bcd_year_t year_inc(input bcd_year_t y);
        bcd_year_t result;
        logic      carry_in;
        result   = y;
        carry_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry_in) begin
                if (result[4*i +: 4] == 4'd9) begin
                    result[4*i +: 4] = 4'd0;
                end else begin
                    result[4*i +: 4] = result[4*i +: 4] + 4'd1;
                    carry_in         = 1'b0;
                end
            end
        end
        year_inc = result;
    endfunction

    assign wrap = (prescaler == PRESC_LAST);
    assign tick = wrap & ~load;

`ifdef TIME_KEEPER_LEAP_EN
    assign run_leap = is_leap(year);
    assign set_leap = is_leap(san_year);
`else
    assign run_leap = 1'b0;
    assign set_leap = 1'b0;
`endif

    assign day_max = month_length(month, run_leap);
    assign set_len = month_length(san_month, set_leap);

    // Year sanitizing: any non-decimal digit becomes 0
    always_comb begin
        san_year = set_year;
        for (int i = 0; i < 4; i++) begin
            if (set_year[4*i +: 4] > 4'd9) begin
                san_year[4*i +: 4] = 4'd0;
            end
        end
    end

    // Month sanitizing feeds the month-length lookup used to clamp the day
    always_comb begin
        san_month = set_month;
        if (!bcd_pair_valid(set_month) || (set_month == 8'h00) || (set_month > MAX_MONTH)) begin
            san_month = 8'h01;
        end
    end

    // Remaining fields: out-of-range time goes to 00, day is clamped, week to Monday
    always_comb begin
        san_sec    = (bcd_pair_valid(set_sec) && (set_sec <= MAX_SEC)) ? set_sec : 8'h00;
        san_minute = (bcd_pair_valid(set_minute) && (set_minute <= MAX_MINUTE)) ? set_minute : 8'h00;
        san_hour   = (bcd_pair_valid(set_hour) && (set_hour <= MAX_HOUR)) ? set_hour : 8'h00;
        san_week   = ((set_week == 4'd0) || (set_week > WEEK_SUN)) ? WEEK_MON : set_week;
        san_day    = set_day;
        if (!bcd_pair_valid(set_day) || (set_day == 8'h00)) begin
            san_day = 8'h01;
        end else if (set_day > set_len) begin
            san_day = set_len;
        end
    end

    // Prescaler: held at zero while loading, wraps after CLK_HZ cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= '0;
        end else if (load || wrap) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    // Seconds strobe registered on the same edge that advances the time
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec_pulse <= 1'b0;
        end else begin
            sec_pulse <= tick;
        end
    end

    bcd2_counter #(.RESET_VALUE(RESET_SEC), .MIN_VALUE(8'h00)) u_sec (
        .clk(clk), .rst_n(rst_n), .clear(1'b0), .load(load), .load_value(san_sec),
        .inc(tick), .max_value(MAX_SEC), .value(sec), .carry(sec_carry)
    );

    bcd2_counter #(.RESET_VALUE(RESET_MINUTE), .MIN_VALUE(8'h00)) u_minute (
        .clk(clk), .rst_n(rst_n), .clear(1'b0), .load(load), .load_value(san_minute),
        .inc(sec_carry), .max_value(MAX_MINUTE), .value(minute), .carry(minute_carry)
    );

    bcd2_counter #(.RESET_VALUE(RESET_HOUR), .MIN_VALUE(8'h00)) u_hour (
        .clk(clk), .rst_n(rst_n), .clear(1'b0), .load(load), .load_value(san_hour),
        .inc(minute_carry), .max_value(MAX_HOUR), .value(hour), .carry(hour_carry)
    );

    bcd2_counter #(.RESET_VALUE(RESET_DAY), .MIN_VALUE(8'h01)) u_day (
        .clk(clk), .rst_n(rst_n), .clear(1'b0), .load(load), .load_value(san_day),
        .inc(hour_carry), .max_value(day_max), .value(day), .carry(day_carry)
    );

    bcd2_counter #(.RESET_VALUE(RESET_MONTH), .MIN_VALUE(8'h01)) u_month (
        .clk(clk), .rst_n(rst_n), .clear(1'b0), .load(load), .load_value(san_month),
        .inc(day_carry), .max_value(MAX_MONTH), .value(month), .carry(month_carry)
    );

    // Year register, advanced by the December rollover
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            year <= RESET_YEAR;
        end else if (load) begin
            year <= san_year;
        end else if (month_carry) begin
            year <= year_inc(year);
        end
    end

    // Weekday advances at midnight, Sunday wraps to Monday
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            week <= RESET_WEEK;
        end else if (load) begin
            week <= san_week;
        end else if (hour_carry) begin
            week <= (week == WEEK_SUN) ? WEEK_MON : week + 4'd1;
        end
    end

endmodule

// File: tb/tb_time_keeper.sv
// Directed self-checking bench for time_keeper with CLK_HZ = 4.
module tb_time_keeper;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [15:0] set_year;
    logic [7:0]  set_month, set_day, set_hour, set_minute, set_sec;
    logic [3:0]  set_week;
    logic [15:0] year;
    logic [7:0]  month, day, hour, minute, sec;
    logic [3:0]  week;
    logic        sec_pulse;

    int compareCount  = 0;
    int mismatchCount = 0;

    time_keeper #(.CLK_HZ(4)) dut (
        .clk(clk), .rst_n(rst_n), .load(load),
        .set_year(set_year), .set_month(set_month), .set_day(set_day),
        .set_hour(set_hour), .set_minute(set_minute), .set_sec(set_sec),
        .set_week(set_week),
        .year(year), .month(month), .day(day), .hour(hour),
        .minute(minute), .sec(sec), .week(week), .sec_pulse(sec_pulse)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Single comparison point: counts and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Compare all calendar fields against hand-computed values
    task automatic checkTime(input string tag, input logic [15:0] y, input logic [7:0] mo,
                             input logic [7:0] d, input logic [7:0] h, input logic [7:0] mi,
                             input logic [7:0] s, input logic [3:0] w);
        checkOutput({tag, ".year"},   {16'h0, year},   {16'h0, y});
        checkOutput({tag, ".month"},  {24'h0, month},  {24'h0, mo});
        checkOutput({tag, ".day"},    {24'h0, day},    {24'h0, d});
        checkOutput({tag, ".hour"},   {24'h0, hour},   {24'h0, h});
        checkOutput({tag, ".minute"}, {24'h0, minute}, {24'h0, mi});
        checkOutput({tag, ".sec"},    {24'h0, sec},    {24'h0, s});
        checkOutput({tag, ".week"},   {28'h0, week},   {28'h0, w});
    endtask

    // Drive set values with load held for exactly one rising edge
    task automatic applyStimulus(input logic [15:0] y, input logic [7:0] mo, input logic [7:0] d,
                                 input logic [7:0] h, input logic [7:0] mi, input logic [7:0] s,
                                 input logic [3:0] w);
        @(negedge clk);
        set_year = y; set_month = mo; set_day = d;
        set_hour = h; set_minute = mi; set_sec = s; set_week = w;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    // Three quiet cycles, then the strobe on the fourth
    task automatic runSecond(input string tag);
        repeat (3) begin
            @(negedge clk);
            checkOutput({tag, ".quiet"}, {31'h0, sec_pulse}, 32'h0);
        end
        @(negedge clk);
        checkOutput({tag, ".pulse"}, {31'h0, sec_pulse}, 32'h1);
    endtask

    initial begin
        load = 1'b0;
        set_year = 16'h0; set_month = 8'h0; set_day = 8'h0;
        set_hour = 8'h0; set_minute = 8'h0; set_sec = 8'h0; set_week = 4'h0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        checkTime("reset", 16'h2000, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 4'd6);
        checkOutput("reset.pulse", {31'h0, sec_pulse}, 32'h0);
        #10 rst_n = 1'b1;

        // First second after reset release
        runSecond("first");
        checkTime("first", 16'h2000, 8'h01, 8'h01, 8'h00, 8'h00, 8'h01, 4'd6);
        @(negedge clk);
        checkOutput("first.drop", {31'h0, sec_pulse}, 32'h0);

        // New year rollover with Sunday -> Monday
        applyStimulus(16'h2023, 8'h12, 8'h31, 8'h23, 8'h59, 8'h59, 4'd7);
        checkTime("ny.load", 16'h2023, 8'h12, 8'h31, 8'h23, 8'h59, 8'h59, 4'd7);
        runSecond("ny");
        checkTime("ny", 16'h2024, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 4'd1);

        // End of February in a leap year
        applyStimulus(16'h2024, 8'h02, 8'h28, 8'h23, 8'h59, 8'h59, 4'd3);
        runSecond("feb24");
`ifdef TIME_KEEPER_LEAP_EN
        checkTime("feb24", 16'h2024, 8'h02, 8'h29, 8'h00, 8'h00, 8'h00, 4'd4);
`else
        checkTime("feb24", 16'h2024, 8'h03, 8'h01, 8'h00, 8'h00, 8'h00, 4'd4);
`endif

        // 2100 is a century year not divisible by 400
        applyStimulus(16'h2100, 8'h02, 8'h28, 8'h23, 8'h59, 8'h59, 4'd7);
        runSecond("feb2100");
        checkTime("feb2100", 16'h2100, 8'h03, 8'h01, 8'h00, 8'h00, 8'h00, 4'd1);

        // 30-day month rollover
        applyStimulus(16'h2010, 8'h06, 8'h30, 8'h23, 8'h59, 8'h59, 4'd1);
        runSecond("jun");
        checkTime("jun", 16'h2010, 8'h07, 8'h01, 8'h00, 8'h00, 8'h00, 4'd2);

        // Year 9999 wraps to 0000
        applyStimulus(16'h9999, 8'h12, 8'h31, 8'h23, 8'h59, 8'h59, 4'd5);
        runSecond("y9999");
        checkTime("y9999", 16'h0000, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 4'd6);

        // Out-of-range load values
        applyStimulus(16'h2023, 8'h13, 8'h32, 8'h24, 8'h00, 8'h00, 4'd0);
        checkTime("san1", 16'h2023, 8'h01, 8'h31, 8'h00, 8'h00, 8'h00, 4'd1);
        applyStimulus(16'h20A3, 8'h02, 8'h29, 8'h1F, 8'h60, 8'h5A, 4'd9);
        checkTime("san2", 16'h2003, 8'h02, 8'h28, 8'h00, 8'h00, 8'h00, 4'd1);
        applyStimulus(16'h2024, 8'h02, 8'h29, 8'h12, 8'h30, 8'h45, 4'd4);
`ifdef TIME_KEEPER_LEAP_EN
        checkTime("san3", 16'h2024, 8'h02, 8'h29, 8'h12, 8'h30, 8'h45, 4'd4);
`else
        checkTime("san3", 16'h2024, 8'h02, 8'h28, 8'h12, 8'h30, 8'h45, 4'd4);
`endif

        // Load raised on the wrap cycle suppresses the advance
        applyStimulus(16'h2010, 8'h06, 8'h30, 8'h10, 8'h59, 8'h59, 4'd4);
        repeat (3) @(negedge clk);
        set_year = 16'h2010; set_month = 8'h06; set_day = 8'h30;
        set_hour = 8'h12; set_minute = 8'h00; set_sec = 8'h09; set_week = 4'd4;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        checkOutput("lwrap.pulse", {31'h0, sec_pulse}, 32'h0);
        checkTime("lwrap", 16'h2010, 8'h06, 8'h30, 8'h12, 8'h00, 8'h09, 4'd4);
        runSecond("units");
        checkTime("units", 16'h2010, 8'h06, 8'h30, 8'h12, 8'h00, 8'h10, 4'd4);

        // Reset in the middle of a second
        applyStimulus(16'h2005, 8'h05, 8'h15, 8'h12, 8'h34, 8'h09, 4'd2);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkTime("midrst", 16'h2000, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 4'd6);
        checkOutput("midrst.pulse", {31'h0, sec_pulse}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        runSecond("postrst");
        checkTime("postrst", 16'h2000, 8'h01, 8'h01, 8'h00, 8'h00, 8'h01, 4'd6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
